// File: rtl/uart_tx_fifo_feeder.sv
// Circular byte FIFO that feeds a UART transmitter one byte at a time: one-cycle
// start pulse with the byte held stable, then wait for the transmitter's done tick.
module uart_tx_fifo_feeder #(
    parameter int NB_DATA   = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr,
    input  logic [NB_DATA-1:0]   i_wr_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_overflow,
    output logic                 o_tx_start,
    output logic [NB_DATA-1:0]   o_tx_data,
    input  logic                 i_tx_done_tick,
    output logic                 o_busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_DONE = 2'b01
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NB_DATA-1:0]     r_mem [DEPTH];
    logic [ADDR_BITS-1:0]   r_wr_ptr;
    logic [ADDR_BITS-1:0]   r_rd_ptr;
    logic [ADDR_BITS:0]     r_count;
    logic                   r_tx_start;
    logic [NB_DATA-1:0]     r_tx_data;
    logic                   r_overflow;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_pop;

    // Full/empty come from the pre-edge count, so a write while full is dropped
    // even if a pop frees a slot on the same edge.
    assign w_full      = (r_count == (ADDR_BITS+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = i_wr && !w_full;
    assign w_pop       = (r_state == IDLE) && !w_empty;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_pop) w_state_next = WAIT_DONE;
            WAIT_DONE: if (i_tx_done_tick) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
            if (w_pop)       r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + (ADDR_BITS+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A pop always moves the FSM into WAIT_DONE, so start follows pop for exactly one cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tx_start <= w_pop;
            r_overflow <= i_wr && w_full;
            if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder: queue-based reference model checked
// every cycle, a vector table, and hand-written multi-cycle corner sequences.
module tb_uart_tx_fifo_feeder;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_wr = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       i_tx_done_tick = 1'b0;
    logic       o_full, o_empty, o_overflow, o_tx_start, o_busy;
    logic [4:0] o_count;
    logic [7:0] o_tx_data;

    uart_tx_fifo_feeder #(.NB_DATA(8), .ADDR_BITS(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_wr_data(i_wr_data),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_overflow(o_overflow),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_done_tick(i_tx_done_tick), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a queue of pending bytes plus "a byte is out with the transmitter".
    logic [7:0] mq[$];
    logic       m_busy = 1'b0;
    logic       m_start = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] dut_log[$];
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    int         tmr = 0;

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         done;
        int         e_count;
        bit         e_start;
        logic [7:0] e_data;
        bit         e_busy;
        bit         e_ovf;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_busy = 1'b0; m_start = 1'b0; m_ovf = 1'b0; m_data = 8'h00;
    endtask

    task automatic step(input bit wr, input logic [7:0] d, input bit done);
        bit full, pop, nbusy;
        i_wr = wr; i_wr_data = d; i_tx_done_tick = done;
        full  = (mq.size() == 16);
        pop   = !m_busy && (mq.size() != 0);
        nbusy = m_busy ? !done : pop;
        m_ovf = wr && full;
        m_start = pop;
        if (pop) m_data = mq.pop_front();
        if (wr && !full) mq.push_back(d);
        m_busy = nbusy;
        @(posedge i_clk); #1;
        cyc++;
        if (o_tx_start) dut_log.push_back(o_tx_data);
        chk("count", int'(o_count), mq.size());
        chk("busy", int'(o_busy), int'(m_busy));
        chk("start", int'(o_tx_start), int'(m_start));
        chk("data", int'(o_tx_data), int'(m_data));
        chk("overflow", int'(o_overflow), int'(m_ovf));
        chk("full", int'(o_full), int'(mq.size() == 16));
        chk("empty", int'(o_empty), int'(mq.size() == 0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, int'(o_tx_start), 0);
        chk({tag, "_data"}, int'(o_tx_data), 0);
        chk({tag, "_count"}, int'(o_count), 0);
        chk({tag, "_empty"}, int'(o_empty), 1);
        chk({tag, "_full"}, int'(o_full), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_ovf"}, int'(o_overflow), 0);
    endtask

    task automatic do_reset();
        #2 i_reset = 1'b1;
        i_wr = 1'b0; i_tx_done_tick = 1'b0;
        #1 chk_reset_outputs("rst");
        model_clear();
        dut_log.delete();
        @(negedge i_clk) i_reset = 1'b0;
    endtask

    // Feeds src_q (when not full) and emulates the transmitter's done tick `delay` cycles after each start.
    task automatic run(input int delay, input int max_cyc, input int gap_max);
        bit wr, done, fin;
        logic [7:0] d;
        fin = 1'b0;
        tmr = 0;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            wr = (src_q.size() != 0) && (mq.size() < 16) && ($urandom_range(0, gap_max) == 0);
            d  = wr ? src_q[0] : 8'h00;
            done = m_busy && (tmr >= delay);
            step(wr, d, done);
            if (wr) void'(src_q.pop_front());
            if (m_start) tmr = 0; else tmr++;
            chk("count_max", int'(o_count <= 5'd16), 1);
            fin = (src_q.size() == 0) && (mq.size() == 0) && !m_busy;
        end
        chk("run_timeout", int'(fin), 1);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, dut_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dut_log.size(); i++)
            chk(name, int'(dut_log[i]), int'(exp_q[i]));
    endtask

    initial begin
        tbl[0] = '{1, 8'hA5, 0, 1, 0, 8'h00, 0, 0};
        tbl[1] = '{0, 8'h00, 0, 0, 1, 8'hA5, 1, 0};
        tbl[2] = '{0, 8'h00, 0, 0, 0, 8'hA5, 1, 0};
        tbl[3] = '{0, 8'h00, 1, 0, 0, 8'hA5, 0, 0};
        tbl[4] = '{0, 8'h00, 1, 0, 0, 8'hA5, 0, 0};
        tbl[5] = '{1, 8'h3C, 0, 1, 0, 8'hA5, 0, 0};
        tbl[6] = '{1, 8'h3D, 0, 1, 1, 8'h3C, 1, 0};

        // Power-on reset, checked before any clock edge
        #1 chk_reset_outputs("por");
        @(negedge i_clk) i_reset = 1'b0;

        // Vector table: single byte, spurious done in IDLE, write on pop edge
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].done);
            chk("tbl_count", int'(o_count), tbl[i].e_count);
            chk("tbl_start", int'(o_tx_start), int'(tbl[i].e_start));
            chk("tbl_data", int'(o_tx_data), int'(tbl[i].e_data));
            chk("tbl_busy", int'(o_busy), int'(tbl[i].e_busy));
            chk("tbl_ovf", int'(o_overflow), int'(tbl[i].e_ovf));
        end

        // Reset mid-transfer, then a late done tick must not start anything
        do_reset();
        step(1, 8'hB1, 0); step(1, 8'hB2, 0); step(1, 8'hB3, 0);
        chk("pre_rst_busy", int'(o_busy), 1);
        do_reset();
        step(0, 8'h00, 1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0);
        chk("post_rst_pulses", dut_log.size(), 0);

        // Burst ordering with 160-cycle transmitter
        do_reset();
        exp_q.delete();
        for (int i = 1; i <= 5; i++) begin src_q.push_back(8'(i)); exp_q.push_back(8'(i)); end
        run(160, 2000, 0);
        chk_log("burst");

        // Full / overflow: 18 writes with no done ticks
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(1, 8'(8'h10 + i), 0);
            if (i == 16) begin
                chk("full_flag", int'(o_full), 1);
                chk("full_count", int'(o_count), 16);
            end
        end
        chk("ovf_pulse", int'(o_overflow), 1);
        step(0, 8'h00, 0);
        chk("ovf_clear", int'(o_overflow), 0);
        exp_q.delete();
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'(8'h10 + i));
        step(0, 8'h00, 1);
        run(3, 1000, 0);
        chk_log("ovf_drain");

        // Simultaneous write and pop with three bytes pending in IDLE
        do_reset();
        step(1, 8'h50, 0); step(0, 8'h00, 0);
        step(1, 8'h51, 0); step(1, 8'h52, 0); step(1, 8'h53, 0);
        step(0, 8'h00, 1);
        chk("sim_pre_count", int'(o_count), 3);
        chk("sim_pre_busy", int'(o_busy), 0);
        step(1, 8'h54, 0);
        chk("sim_count", int'(o_count), 3);
        chk("sim_start", int'(o_tx_start), 1);
        chk("sim_data", int'(o_tx_data), 8'h51);

        // Wrap-around: 40 random bytes with random gaps
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            src_q.push_back(b); exp_q.push_back(b);
        end
        run(10, 5000, 2);
        chk_log("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
